// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment capture block: active-low segment
// patterns ordered {g,f,e,d,c,b,a} and the decode result struct.
package seven_seg_pkg;

  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_0     = 7'b1000000;
  localparam seg_pattern_t SEG_1     = 7'b1111001;
  localparam seg_pattern_t SEG_2     = 7'b0100100;
  localparam seg_pattern_t SEG_3     = 7'b0110000;
  localparam seg_pattern_t SEG_4     = 7'b0011001;
  localparam seg_pattern_t SEG_5     = 7'b0010010;
  localparam seg_pattern_t SEG_6     = 7'b0000010;
  localparam seg_pattern_t SEG_7     = 7'b1111000;
  localparam seg_pattern_t SEG_8     = 7'b0000000;
  localparam seg_pattern_t SEG_9     = 7'b0010000;
  localparam seg_pattern_t SEG_A     = 7'b0001000;
  localparam seg_pattern_t SEG_B     = 7'b0000011;
  localparam seg_pattern_t SEG_C     = 7'b1000110;
  localparam seg_pattern_t SEG_D     = 7'b0100001;
  localparam seg_pattern_t SEG_E     = 7'b0000110;
  localparam seg_pattern_t SEG_F     = 7'b0001110;
  localparam seg_pattern_t SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] value;
    logic       valid;
    logic       blank;
    logic       illegal;
  } seg_decode_t;

endpackage

// File: rtl/seven_seg_pattern_encoder.sv
// Combinational segment-pattern to digit decoder.
// Hex letters A-F are legal only when SEVEN_SEG_CAPTURE_HEX_EN is defined.
module seven_seg_pattern_encoder
  import seven_seg_pkg::*;
(
  input  seg_pattern_t seg_i,
  output seg_decode_t  dec_o
);

  always_comb begin
    dec_o.value   = 4'd0;
    dec_o.valid   = 1'b1;
    dec_o.blank   = 1'b0;
    dec_o.illegal = 1'b0;
    case (seg_i)
      SEG_0: dec_o.value = 4'd0;
      SEG_1: dec_o.value = 4'd1;
      SEG_2: dec_o.value = 4'd2;
      SEG_3: dec_o.value = 4'd3;
      SEG_4: dec_o.value = 4'd4;
      SEG_5: dec_o.value = 4'd5;
      SEG_6: dec_o.value = 4'd6;
      SEG_7: dec_o.value = 4'd7;
      SEG_8: dec_o.value = 4'd8;
      SEG_9: dec_o.value = 4'd9;
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
      SEG_A: dec_o.value = 4'hA;
      SEG_B: dec_o.value = 4'hB;
      SEG_C: dec_o.value = 4'hC;
      SEG_D: dec_o.value = 4'hD;
      SEG_E: dec_o.value = 4'hE;
      SEG_F: dec_o.value = 4'hF;
`endif
      SEG_BLANK: begin
        dec_o.valid = 1'b0;
        dec_o.blank = 1'b1;
      end
      default: begin
        dec_o.valid   = 1'b0;
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed active-low seven-segment bus back into per-position
// digit registers after STABLE_CYCLES identical samples. Hex: SEVEN_SEG_CAPTURE_HEX_EN.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic                    update_o,
  output logic                    err_o
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = 1;

  logic [SW-1:0]           in_w, s_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q, blank_q, sel;
  logic                    update_q, err_q;
  logic                    same, commit, sel_none, sel_one, sel_multi;
  logic                    write_en, err_set, changed;
  seg_decode_t             dec;

  assign in_w   = {an_n, seg};
  assign same   = (in_w == s_q);
  assign commit = same && (cnt_q == CNT_COMMIT);
  assign cnt_d  = !same ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Active-high position select derived from the sampled anode strobes.
  assign sel       = ~s_q[SW-1:7];
  assign sel_none  = (sel == '0);
  assign sel_one   = !sel_none && ((sel & (sel - SEL_ONE)) == '0);
  assign sel_multi = !sel_none && !sel_one;

  seven_seg_pattern_encoder u_enc (
    .seg_i (s_q[6:0]),
    .dec_o (dec)
  );

  assign write_en = commit && sel_one;
  assign err_set  = commit && (sel_multi || (sel_one && dec.illegal));

  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i] && ({digits_q[4*i +: 4], valid_q[i], blank_q[i]} !=
                     {dec.value, dec.valid, dec.blank}))
        changed = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= '1;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '1;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= in_w;
      cnt_q    <= cnt_d;
      update_q <= write_en && changed;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (write_en && sel[i]) begin
          digits_q[4*i +: 4] <= dec.value;
          valid_q[i]         <= dec.valid;
          blank_q[i]         <= dec.blank;
        end
      end
      // A new error outranks a simultaneous clear.
      if (err_set)      err_q <= 1'b1;
      else if (clear_i) err_q <= 1'b0;
    end
  end

  assign digits_o = digits_q;
  assign valid_o  = valid_q;
  assign blank_o  = blank_q;
  assign update_o = update_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: run-length reference model with
// an update scoreboard, directed scenarios followed by random bus traffic.
module tb_seven_seg_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  typedef struct packed {
    logic [4*ND-1:0] d;
    logic [ND-1:0]   v;
    logic [ND-1:0]   b;
  } view_t;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, clear_i, update_o, err_o;
  logic [ND-1:0]   an_n, valid_o, blank_o;
  logic [6:0]      seg;
  logic [4*ND-1:0] digits_o;

  seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .an_n     (an_n),
    .seg      (seg),
    .clear_i  (clear_i),
    .digits_o (digits_o),
    .valid_o  (valid_o),
    .blank_o  (blank_o),
    .update_o (update_o),
    .err_o    (err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [6:0]    pat_tab[16];
  logic [3:0]    m_dig[ND];
  logic          m_vld[ND];
  logic          m_blk[ND];
  logic          m_err;
  int            run;
  logic [ND+6:0] prev;
  view_t         exp_q[$];
  bit            mon_en = 1'b0;

  function automatic view_t model_view();
    view_t r;
    for (int i = 0; i < ND; i++) begin
      r.d[4*i +: 4] = m_dig[i];
      r.v[i]        = m_vld[i];
      r.b[i]        = m_blk[i];
    end
    return r;
  endfunction

  // Applies what the DUT should do at the edge that samples these inputs.
  task automatic model_edge(input logic [ND-1:0] an, input logic [6:0] sg,
                            input logic clr, input logic rst);
    logic [ND-1:0] mask;
    int code, idx, hex_lim;
    logic [3:0] val;
    logic vld, blk, ill;
    if (!rst) begin
      for (int i = 0; i < ND; i++) begin
        m_dig[i] = 4'd0; m_vld[i] = 1'b0; m_blk[i] = 1'b1;
      end
      m_err = 1'b0;
      run   = 0;
      exp_q.delete();
      return;
    end
    if (run > 0 && {an, sg} == prev) run++;
    else run = 1;
    prev = {an, sg};
    if (clr) m_err = 1'b0;
    if (run != SC) return;
    mask = ~an;
    if ($countones(mask) > 1) begin
      m_err = 1'b1;
      return;
    end
    if (mask == '0) return;
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
    hex_lim = 16;
`else
    hex_lim = 10;
`endif
    code = -1;
    for (int k = 0; k < hex_lim; k++) if (sg == pat_tab[k]) code = k;
    val = 4'd0; vld = 1'b0; blk = 1'b0; ill = 1'b0;
    if (code >= 0) begin val = 4'(code); vld = 1'b1; end
    else if (sg == 7'h7f) blk = 1'b1;
    else ill = 1'b1;
    if (ill) m_err = 1'b1;
    idx = 0;
    for (int i = 0; i < ND; i++) if (mask[i]) idx = i;
    if (m_dig[idx] != val || m_vld[idx] != vld || m_blk[idx] != blk) begin
      m_dig[idx] = val; m_vld[idx] = vld; m_blk[idx] = blk;
      exp_q.push_back(model_view());
    end
  endtask

  // Driver tasks
  task automatic step(input logic [ND-1:0] an, input logic [6:0] sg,
                      input logic clr, input logic rst);
    @(negedge clk);
    an_n = an; seg = sg; clear_i = clr; rst_n = rst;
    model_edge(an, sg, clr, rst);
  endtask

  task automatic hold(input logic [ND-1:0] an, input logic [6:0] sg, input int n);
    for (int k = 0; k < n; k++) step(an, sg, 1'b0, 1'b1);
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      view_t got, want;
      got  = '{d: digits_o, v: valid_o, b: blank_o};
      want = model_view();
      checks++;
      if (got != want || err_o !== m_err) begin
        errors++;
        $display("FAIL state: got d=%h v=%b b=%b e=%b, want d=%h v=%b b=%b e=%b",
                 got.d, got.v, got.b, err_o, want.d, want.v, want.b, m_err);
      end
      checks++;
      if (update_o !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL update: got %b, want %b", update_o, exp_q.size() != 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (update_o) begin
        want = exp_q.pop_front();
        checks++;
        if (got != want) begin
          errors++;
          $display("FAIL update_view: got d=%h v=%b b=%b, want d=%h v=%b b=%b",
                   got.d, got.v, got.b, want.d, want.v, want.b);
        end
      end
    end
  end

  initial begin
    logic [ND-1:0] an;
    logic [6:0] sg;
    int n, sel;
    pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001; pat_tab[2]  = 7'b0100100;
    pat_tab[3]  = 7'b0110000; pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
    pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000; pat_tab[8]  = 7'b0000000;
    pat_tab[9]  = 7'b0010000; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
    pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001; pat_tab[14] = 7'b0000110;
    pat_tab[15] = 7'b0001110;
    rst_n = 1'b0; clear_i = 1'b0; an_n = '1; seg = 7'h7f;
    prev = '1;
    model_edge('1, 7'h7f, 1'b0, 1'b0);

    // Reset
    step(4'b1111, 7'h7f, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(4'b1111, 7'h7f, 1'b0, 1'b0);
    // Single commit, then a long hold
    hold(4'b1110, pat_tab[3], 14);
    // Glitch rejection, then a no-change blank commit
    hold(4'b1101, pat_tab[2], 3);
    hold(4'b1101, 7'h7f, 6);
    // Full scan 1,2,3,4
    for (int p = 0; p < ND; p++) begin
      hold(~(4'b0001 << p), pat_tab[p+1], 8);
      hold(4'b1111, 7'h7f, 2);
    end
    // Multi-hot anode
    hold(4'b1100, pat_tab[1], 4);
    step(4'b1111, 7'h7f, 1'b1, 1'b1);
    hold(4'b1111, 7'h7f, 2);
    // Hex letter A on position 0
    hold(4'b1110, pat_tab[10], 5);
    step(4'b1111, 7'h7f, 1'b1, 1'b1);
    hold(4'b1111, 7'h7f, 2);
    // Clear coinciding with an error commit
    hold(4'b1010, pat_tab[7], 3);
    step(4'b1010, pat_tab[7], 1'b1, 1'b1);
    hold(4'b1111, 7'h7f, 2);
    step(4'b1111, 7'h7f, 1'b1, 1'b1);
    // Reset mid-run, then recommit with the same input
    hold(4'b1011, pat_tab[5], 3);
    step(4'b1011, pat_tab[5], 1'b0, 1'b0);
    hold(4'b1011, pat_tab[5], 6);

    // Random bus traffic
    for (int r = 0; r < 250; r++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) an = '1;
      else if (sel < 9) an = ~(4'b0001 << $urandom_range(0, ND-1));
      else an = ~(4'b0011 << $urandom_range(0, ND-2));
      sel = $urandom_range(0, 19);
      if (sel < 16) sg = pat_tab[sel];
      else if (sel < 18) sg = 7'h7f;
      else sg = 7'($urandom);
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++)
        step(an, sg, (k == 0) && ($urandom_range(0, 7) == 0), 1'b1);
    end
    hold(4'b1111, 7'h7f, 3);

    @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_updates: got %0d left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
